// File: rtl/uart_tx_fifo_drain_pkg.sv
// uart_tx_pkg: shared state type and line-level constants
// for the UART TX FIFO drain.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: read port of the async TX FIFO.
// master = drain side (pops), slave = FIFO side.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  R_INC;

  modport master (
    input  EMPTY,
    input  RD_DATA,
    output R_INC
  );

  modport slave (
    output EMPTY,
    output RD_DATA,
    input  R_INC
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register with a
// data bit counter that flags the last data bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_out,
  output logic                  done
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data_in;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
      // counter reloads instead of overflowing
      cnt   <= done ? '0 : cnt + 1'b1;
    end
  end

  assign bit_out = shreg[0];
  assign done    = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops the TX FIFO and sends each word
// as a UART frame, one bit per CLK, back-to-back when able.
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  uart_tx_fifo_drain_if.master       fifo,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  output logic                       TX_OUT,
  output logic                       BUSY
);

  tx_state_e state;
  tx_state_e state_nxt;
  logic      capture;
  logic      par_en_q;
  logic      par_bit_q;
  logic      busy_q;
  logic      r_inc_q;
  logic      ser_bit;
  logic      ser_done;
  logic      shift_en;

  assign shift_en = (state == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (capture),
    .shift_en (shift_en),
    .data_in  (fifo.RD_DATA),
    .bit_out  (ser_bit),
    .done     (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      r_inc_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_q  <= (state_nxt != IDLE);
      r_inc_q <= capture;
      if (capture) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (PAR_TYP == PAR_ODD) ?
                     ~^fifo.RD_DATA : ^fifo.RD_DATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo.EMPTY) begin
          capture   = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = DATA;
      DATA: begin
        if (ser_done)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: state_nxt = STOP;
      STOP: begin
        // chain straight into the next frame, no idle gap
        if (!fifo.EMPTY) begin
          capture   = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT = IDLE_LEVEL;
    unique case (state)
      START:   TX_OUT = START_BIT;
      DATA:    TX_OUT = ser_bit;
      PARITY:  TX_OUT = par_bit_q;
      STOP:    TX_OUT = STOP_BIT;
      default: TX_OUT = IDLE_LEVEL;
    endcase
  end

  assign BUSY       = busy_q;
  assign fifo.R_INC = r_inc_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: FIFO model + scoreboard of expected
// UART frames, checked by a line monitor.
module tb_uart_tx_fifo_drain;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] w;
    bit            pe;
    bit            pt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic TX_OUT;
  logic BUSY;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(DW)) f();

  uart_tx_fifo_drain #(.DATA_WIDTH(DW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .fifo    (f),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .TX_OUT  (TX_OUT),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            rinc_cyc[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_seen = 1'b1;
  bit pop_pend = 1'b0;
  bit in_frame = 1'b0;
  int idx = 0;
  int exp_len = 0;
  logic [15:0] exp_bits;
  logic [15:0] act_bits;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Expected frame from the UART rules: start, LSB-first
  // data, optional parity (total ones even/odd), stop.
  function automatic int build(input exp_t e,
                               output logic [15:0] b);
    int n;
    bit p;
    b = '0;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = e.w[i];
    n = 1 + DW;
    if (e.pe) begin
      p = (($countones(e.w) % 2) == 1) ^ e.pt;
      b[n] = p;
      n++;
    end
    b[n] = 1'b1;
    n++;
    return n;
  endfunction

  // FIFO model: pop on the edge after R_INC was seen high
  always @(posedge CLK) begin
    cyc++;
    rst_seen = !RST;
    if (pop_pend && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    #1;
    f.EMPTY = (fifo_q.size() == 0);
    f.RD_DATA = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Line monitor / scoreboard
  always @(negedge CLK) begin
    if (cyc > 0) begin
      pop_pend = (f.R_INC === 1'b1);
      if (pop_pend) begin
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL pop_on_empty: R_INC=1 with empty FIFO (cycle %0d)",
                   cyc);
        end
      end
      if (rst_seen) begin
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_rinc", f.R_INC, 0);
        in_frame = 1'b0;
      end else if (in_frame) begin
        act_bits[idx] = TX_OUT;
        chk("frame_busy", BUSY, 1);
        chk("frame_rinc", f.R_INC, 0);
        idx++;
        if (idx == exp_len) begin
          chk("frame_bits", act_bits, exp_bits);
          in_frame = 1'b0;
        end
      end else if (TX_OUT === 1'b0) begin
        chk("start_busy", BUSY, 1);
        chk("start_rinc", f.R_INC, 1);
        rinc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit expected idle (cycle %0d)",
                   cyc);
        end else begin
          exp_len = build(exp_q.pop_front(), exp_bits);
          act_bits = '0;
          act_bits[0] = TX_OUT;
          idx = 1;
          in_frame = 1'b1;
        end
      end else begin
        chk("idle_tx", TX_OUT, 1);
        chk("idle_busy", BUSY, 0);
        chk("idle_rinc", f.R_INC, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    exp_t e;
    e.w = w;
    e.pe = PAR_EN;
    e.pt = PAR_TYP;
    fifo_q.push_back(w);
    exp_q.push_back(e);
    f.EMPTY = 1'b0;
    f.RD_DATA = fifo_q[0];
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (fifo_q.size() == 0 && exp_q.size() == 0 &&
          !in_frame && BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    step(2);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle within %0d cycles",
               max);
    end
  endtask

  task automatic wait_rinc(input int n0, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rinc_cyc.size() > n0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no frame expected one within %0d cycles",
               max);
    end
  endtask

  int n0;
  int nw;

  initial begin
    f.EMPTY = 1'b1;
    f.RD_DATA = '0;
    RST = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    step(1);
    push(8'hA5);
    step(3);
    chk("rst_no_pop", fifo_q.size(), 1);
    RST = 1'b1;
    wait_idle(50);
    chk("a5_rinc_count", rinc_cyc.size(), 1);

    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    push(8'h03);
    wait_idle(50);
    PAR_TYP = 1'b1;
    push(8'h03);
    wait_idle(50);
    PAR_TYP = 1'b0;
    push(8'h07);
    wait_idle(50);

    PAR_EN = 1'b0;
    n0 = rinc_cyc.size();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_idle(80);
    chk("b2b_count", rinc_cyc.size() - n0, 3);
    if (rinc_cyc.size() - n0 == 3) begin
      chk("b2b_gap1", rinc_cyc[n0+1] - rinc_cyc[n0], 10);
      chk("b2b_gap2", rinc_cyc[n0+2] - rinc_cyc[n0+1], 10);
    end

    n0 = rinc_cyc.size();
    push(8'h5A);
    wait_rinc(n0, 20);
    push(8'hC3);
    step(5);
    RST = 1'b0;
    step(1);
    RST = 1'b1;
    wait_idle(50);
    chk("rst_mid_rinc", rinc_cyc.size() - n0, 2);

    PAR_EN = 1'b0;
    n0 = rinc_cyc.size();
    push(8'h3C);
    wait_rinc(n0, 20);
    step(3);
    PAR_EN = 1'b1;
    push(8'hC5);
    wait_idle(60);
    chk("cfg_rinc", rinc_cyc.size() - n0, 2);
    if (rinc_cyc.size() - n0 == 2)
      chk("cfg_gap", rinc_cyc[n0+1] - rinc_cyc[n0], 10);

    for (int b = 0; b < 20; b++) begin
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) begin
        push(DW'($urandom));
        step($urandom_range(0, 6));
      end
      wait_idle(200);
    end

    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_fifo_empty", fifo_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Read-side consumer of the asynchronous TX FIFO, clocked in the FIFO read domain. Whenever the FIFO is non-empty and the transmitter is free, it captures `RD_DATA`, issues a single-cycle `R_INC` pop, and serialises the word as a UART frame: start bit, data LSB-first, optional parity, stop. One bit is sent per `CLK` cycle; `CLK` is the baud-rate clock, the same clock as the FIFO read clock.

## Interface
- `DATA_WIDTH`, 8, FIFO word width and number of data bits per frame.
- `CLK` in 1: TX/baud clock, same net as the FIFO read clock.
- `RST` in 1: synchronous, active-low reset.
- `EMPTY` in 1: FIFO empty flag, read-domain synchronised.
- `RD_DATA` in `DATA_WIDTH`: FIFO head word, combinational from the FIFO RAM, valid whenever `EMPTY`=0.
- `R_INC` out 1: FIFO pop request, one-cycle pulse.
- `PAR_EN` in 1: 1 = parity bit inserted.
- `PAR_TYP` in 1: 0 = even parity, 1 = odd parity.
- `TX_OUT` out 1: serial line, idle high.
- `BUSY` out 1: high while a frame is in progress.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - On an edge with `RST`=1 and `EMPTY`=0: load `RD_DATA` into the shift register, latch `PAR_EN`/`PAR_TYP`, compute the parity bit, then go to START.
  - Otherwise stay in IDLE.
- **START:** `TX_OUT`=0 for one cycle, then DATA with bit count 0.
- **DATA:**
  - `TX_OUT` = shift register bit 0; shift right every cycle.
  - After `DATA_WIDTH` cycles, go to PARITY if latched `PAR_EN`=1, else STOP.
- **PARITY:**
  - `TX_OUT` = `^data` for even parity, `~^data` for odd parity.
  - Computed on the captured word; lasts one cycle.
- **STOP:**
  - `TX_OUT`=1 for one cycle.
  - At the end of STOP, if `EMPTY`=0: capture the next word exactly as in IDLE and go straight to START, giving zero idle gap between frames.
  - Otherwise go to IDLE.
- **`R_INC`:**
  - Registered; high only in the cycle immediately after a capture edge.
  - The FIFO pointer therefore advances on the following edge.
  - `R_INC` is never high while `EMPTY`=1 at its asserting edge. This holds because capture requires `EMPTY`=0, and a frame of at least 10 cycles exceeds the pointer-sync latency.
- **`BUSY`:** registered; 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **Config pins:** changes to `PAR_EN`/`PAR_TYP` mid-frame have no effect on the frame in flight.
- **Reset values:** `TX_OUT`=1, `BUSY`=0, `R_INC`=0, state IDLE, shift register 0, bit counter 0.
- **Reset mid-frame:** at the next edge with `RST`=0, all outputs take their reset values. The partially sent word is dropped; it is not re-read, because it was already popped.
- **Reset during the `R_INC` cycle:** `R_INC` deasserts at that edge. Whether the FIFO pops is then governed by the FIFO's own reset.

## Timing
- **Capture edge = k** (`EMPTY`=0 sampled in IDLE):
  - `R_INC`=1 during cycle k..k+1.
  - `BUSY`=1 from k.
  - `TX_OUT` start bit during k..k+1.
  - Data bit i during k+1+i..k+2+i.
  - Parity bit, if enabled, during k+1+DATA_WIDTH.
  - Stop bit in the final cycle.
- **Frame length:** `DATA_WIDTH`+2 cycles without parity; `DATA_WIDTH`+3 with parity (10 / 11 at the default).
- **Back-to-back frames:** the next start bit immediately follows the stop bit. Pops are spaced exactly one frame length apart.
- **Latency:** from `EMPTY` falling (as sampled at edge k) to the start bit on the line: 0 cycles after edge k.
- **Bit counter:** width `$clog2(DATA_WIDTH)`; wraps only via FSM reload, with no arithmetic overflow.

## Structure
- **Package `uart_tx_pkg`:**
  - state enum `tx_state_e`;
  - `PAR_EVEN`=0, `PAR_ODD`=1;
  - `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1.
- **Sub-module `uart_tx_serializer`:**
  - contains the shift register, bit counter and `done` flag;
  - interface: load, shift enable, data in, serial bit out, done.
- **Top level:** FSM, capture/`R_INC` logic, parity, output mux.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles with `EMPTY`=0.
  - Outputs stay at `TX_OUT`=1, `BUSY`=0, `R_INC`=0; no pop occurs.
- **Single word, no parity:** `EMPTY`=0, `RD_DATA`=8'hA5, `PAR_EN`=0.
  - One `R_INC` pulse.
  - `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1.
  - `BUSY` high for 10 cycles.
- **Parity modes:**
  - 8'h03, even parity: parity bit 0.
  - 8'h03, odd parity: parity bit 1.
  - 8'h07, even parity: parity bit 1.
  - Frame length 11 in all cases.
- **Back-to-back:** FIFO preloaded with 8'h11, 8'h22, 8'h33.
  - Three contiguous 10-bit frames with no idle cycle.
  - `R_INC` pulses exactly 10 cycles apart.
  - The line then idles high with `BUSY`=0.
- **Reset mid-frame:** `RST`=0 during data bit 4.
  - Next edge: `TX_OUT`=1, `BUSY`=0.
  - After release with `EMPTY`=0: a fresh frame starts with a new `R_INC`.
- **Mid-frame config change:** toggle `PAR_EN` 0→1 during DATA.
  - The current frame stays 10 bits.
  - The next frame is 11 bits.
